// File: rtl/spi_master_arbiter.sv
// Round-robin arbiter sharing one SPI master between NUM_REQUESTERS clients; define SPI_ARBITER_TIMEOUT_EN for the WAIT watchdog.
// Grant one cycle after request; requests are level-held until grant, and the master's done pulse ends the busy window.
module spi_master_arbiter #(
    parameter int NUM_REQUESTERS  = 4,
    parameter int DATA_WIDTH      = 32,
    parameter int CS_SETUP_CYCLES = 2,
    parameter int CS_HOLD_CYCLES  = 2,
    parameter int TIMEOUT_CYCLES  = 4096
) (
    input  logic                                 clock,
    input  logic                                 reset_n,
    input  logic [NUM_REQUESTERS-1:0]            request,
    input  logic [NUM_REQUESTERS*DATA_WIDTH-1:0] request_data,
    input  logic [NUM_REQUESTERS-1:0]            request_clock_polarity,
    input  logic [NUM_REQUESTERS-1:0]            request_clock_phase,
    output logic [NUM_REQUESTERS-1:0]            grant,
    output logic [NUM_REQUESTERS-1:0]            response_valid,
    output logic [DATA_WIDTH-1:0]                response_data,
    output logic                                 response_error,
    output logic                                 master_enable,
    output logic [DATA_WIDTH-1:0]                master_write_data,
    output logic                                 master_clock_polarity,
    output logic                                 master_clock_phase,
    output logic [NUM_REQUESTERS-1:0]            master_chip_select,
    input  logic                                 master_done,
    input  logic [DATA_WIDTH-1:0]                master_read_data
);

    localparam int IDX_W   = $clog2(NUM_REQUESTERS);
    localparam int CNT_MAX = (CS_SETUP_CYCLES > CS_HOLD_CYCLES) ? CS_SETUP_CYCLES : CS_HOLD_CYCLES;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam logic [NUM_REQUESTERS-1:0] OWNER_LSB = NUM_REQUESTERS'(1);

    typedef enum logic [2:0] {IDLE, SETUP, START, WAIT, HOLD, RESPOND} state_t;

    state_t             state;
    logic [IDX_W-1:0]   last_owner;
    logic [IDX_W-1:0]   win_idx;
    logic               win_vld;
    logic [CNT_W-1:0]   phase_cnt;

    function automatic logic [IDX_W-1:0] wrap_idx(input logic [IDX_W-1:0] base, input int off);
        int sum;
        sum = int'(base) + off;
        return IDX_W'(sum % NUM_REQUESTERS);
    endfunction

    // Search starts just after the previous owner so every requester gets a turn.
    always_comb begin
        win_vld = 1'b0;
        win_idx = '0;
        for (int k = 1; k <= NUM_REQUESTERS; k++) begin
            if (!win_vld && request[wrap_idx(last_owner, k)]) begin
                win_vld = 1'b1;
                win_idx = wrap_idx(last_owner, k);
            end
        end
    end

`ifdef SPI_ARBITER_TIMEOUT_EN
    localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [TO_W-1:0] wd_cnt;
    logic            err_q;
    logic            resp_err_q;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            wd_cnt     <= '0;
            err_q      <= 1'b0;
            resp_err_q <= 1'b0;
        end else begin
            case (state)
                IDLE:    err_q <= 1'b0;
                START:   wd_cnt <= '0;
                WAIT: begin
                    if (!master_done) begin
                        if (wd_cnt == TO_W'(TIMEOUT_CYCLES - 1)) err_q <= 1'b1;
                        else                                      wd_cnt <= wd_cnt + 1'b1;
                    end
                end
                HOLD:    if (phase_cnt == CNT_W'(CS_HOLD_CYCLES - 1)) resp_err_q <= err_q;
                RESPOND: resp_err_q <= 1'b0;
                default: ;
            endcase
        end
    end

    wire wd_expired = (wd_cnt == TO_W'(TIMEOUT_CYCLES - 1));
    assign response_error = resp_err_q;
`else
    wire wd_expired = 1'b0;
    assign response_error = 1'b0;
`endif

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state                 <= IDLE;
            last_owner            <= IDX_W'(NUM_REQUESTERS - 1);
            phase_cnt             <= '0;
            grant                 <= '0;
            response_valid        <= '0;
            response_data         <= '0;
            master_enable         <= 1'b0;
            master_write_data     <= '0;
            master_clock_polarity <= 1'b0;
            master_clock_phase    <= 1'b0;
            master_chip_select    <= '1;
        end else begin
            master_enable  <= 1'b0;
            response_valid <= '0;
            case (state)
                IDLE: begin
                    if (win_vld) begin
                        grant                 <= OWNER_LSB << win_idx;
                        master_chip_select    <= ~(OWNER_LSB << win_idx);
                        master_write_data     <= request_data[win_idx*DATA_WIDTH +: DATA_WIDTH];
                        master_clock_polarity <= request_clock_polarity[win_idx];
                        master_clock_phase    <= request_clock_phase[win_idx];
                        last_owner            <= win_idx;
                        phase_cnt             <= '0;
                        state                 <= SETUP;
                    end
                end
                SETUP: begin
                    if (phase_cnt == CNT_W'(CS_SETUP_CYCLES - 1)) begin
                        master_enable <= 1'b1;
                        state         <= START;
                    end else begin
                        phase_cnt <= phase_cnt + 1'b1;
                    end
                end
                START: state <= WAIT;
                WAIT: begin
                    // A watchdog abort reports a zero read word alongside the error flag.
                    if (master_done) begin
                        response_data <= master_read_data;
                        phase_cnt     <= '0;
                        state         <= HOLD;
                    end else if (wd_expired) begin
                        response_data <= '0;
                        phase_cnt     <= '0;
                        state         <= HOLD;
                    end
                end
                HOLD: begin
                    if (phase_cnt == CNT_W'(CS_HOLD_CYCLES - 1)) begin
                        master_chip_select <= '1;
                        response_valid     <= grant;
                        state              <= RESPOND;
                    end else begin
                        phase_cnt <= phase_cnt + 1'b1;
                    end
                end
                RESPOND: begin
                    grant <= '0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
